instruction_fetch: RTL
======================

Name: instruction_fetch

Overview:
Parametrised successor to the combinational instruction memory. It owns the program counter, a loadable instruction store with a registered read, and per-field decode of opcode/reg1/reg2. Control flow is sequential increment, absolute or PC-relative branch, stall and halt. It sits between the program loader/testbench and the decode/control stage of the core.

Parameters:
PC_BITS, 12, PC and address width; store depth is 2**PC_BITS words.
OP_BITS, 3, opcode field width.
FIELD_BITS, 3, width of each of reg1 and reg2.
INS_WIDTH, OP_BITS+2*FIELD_BITS (9), instruction word width; any other value is illegal.
START_PC, 0, first fetch address after start.
HALT_OP, 3'b111, opcode that halts fetch.

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
start  in  1  begin execution from START_PC; honoured in IDLE or HALT only
load_en  in  1  program-store write strobe; honoured in IDLE or HALT only
load_addr  in  PC_BITS  write address
load_data  in  INS_WIDTH  write data
stall  in  1  freeze fetch and outputs
branch_en  in  1  redirect the next fetch
branch_rel  in  1  1 = relative (pc + offset), 0 = absolute target
branch_target  in  PC_BITS  absolute target, or two's-complement offset when branch_rel=1
pc  out  PC_BITS  address of the instruction on the outputs
ins_valid  out  1  outputs hold a valid fetched instruction
opcode  out  OP_BITS  ins[INS_WIDTH-1 -: OP_BITS]
reg1  out  FIELD_BITS  next FIELD_BITS below the opcode
reg2  out  FIELD_BITS  ins[FIELD_BITS-1:0]
halted  out  1  state == HALT
busy  out  1  state == RUN

Behaviour:
- States: IDLE, RUN, HALT.
- Reset: state IDLE; fetch_pc, pc and instruction register cleared to 0; ins_valid, halted and busy are 0. Store contents are not reset. Reset overrides every other input, including mid-RUN.
- IDLE/HALT:
  - load_en writes mem[load_addr] <= load_data.
  - start sets state to RUN, fetch_pc <= START_PC, ins_valid <= 0, halted <= 0.
  - A load and a start in the same cycle both take effect; the written word is visible to the first fetch.
  - stall and branch inputs are ignored.
- RUN, not stalled, each cycle:
  - fetch address a = branch_en ? (branch_rel ? pc + branch_target : branch_target) : fetch_pc.
  - Then ins_reg <= mem[a], pc <= a, fetch_pc <= a + 1, ins_valid <= 1.
  - Read latency is 1 cycle. A branch costs no bubble: the word at the target appears on the next cycle.
- Arithmetic: all PC arithmetic is modulo 2**PC_BITS. fetch_pc wraps from 2**PC_BITS-1 to 0. A relative offset wraps the same way (pc=0, offset=all-ones gives max address).
- Relative branches are taken from pc, the address of the instruction currently on the outputs.
- RUN, stalled: every register holds, outputs are stable and branch_en is ignored. The consumer must hold the branch request until the cycle it is not stalled.
- Halt:
  - Condition: RUN, not stalled, ins_valid=1 and opcode==HALT_OP.
  - Next state is HALT and ins_valid <= 0. pc and the fields keep their last value, so pc reports the halt address.
  - halt has priority over a branch asserted in the same cycle.
- load_en during RUN is ignored; the store is not modified.
- The first valid instruction appears two cycles after start: start cycle, then the fetch cycle.

Test Plan:
- Load mem[0..3] = 9'o012, 9'o345, 9'o101, 9'o700, then pulse start -> ins_valid rises 2 cycles later. pc runs 0,1,2,3 with (opcode,reg1,reg2) = (0,1,2),(3,4,5),(1,0,1),(7,0,0). halted=1 on the cycle after pc=3 shows, with ins_valid=0 and pc held at 3.
- Absolute branch: branch_en=1, branch_rel=0, target=12'h080 while pc=1 -> next cycle pc=0x080 with mem[0x080] fields and no invalid gap; the following cycle pc=0x081.
- Relative branch backwards: pc=5, branch_rel=1, target=12'hFFD (-3) -> next pc=2. At pc=0 with offset 12'hFFF -> next pc=12'hFFF, then fetch wraps to pc=0.
- Stall: assert stall for 3 cycles at pc=2 with branch_en=1 held -> pc, fields and ins_valid frozen. On release the branch is taken exactly once.
- Load during RUN to address 1 -> contents unchanged. After halt, reload mem[1] and start -> the new word is fetched at pc=1.
- Synchronous reset asserted mid-RUN at pc=7 -> next edge gives state IDLE, pc=0, ins_valid=0, busy=0. A following start with no reload re-executes the retained program.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: program counter, loadable instruction store with a
// registered read, and opcode/reg1/reg2 field decode with branch, stall and halt.
module instruction_fetch #(
   parameter int                 PC_BITS    = 12,
   parameter int                 OP_BITS    = 3,
   parameter int                 FIELD_BITS = 3,
   parameter int                 INS_WIDTH  = OP_BITS + 2*FIELD_BITS,
   parameter logic [PC_BITS-1:0] START_PC   = '0,
   parameter logic [OP_BITS-1:0] HALT_OP    = '1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  load_en,
   input  logic [PC_BITS-1:0]    load_addr,
   input  logic [INS_WIDTH-1:0]  load_data,
   input  logic                  stall,
   input  logic                  branch_en,
   input  logic                  branch_rel,
   input  logic [PC_BITS-1:0]    branch_target,
   output logic [PC_BITS-1:0]    pc,
   output logic                  ins_valid,
   output logic [OP_BITS-1:0]    opcode,
   output logic [FIELD_BITS-1:0] reg1,
   output logic [FIELD_BITS-1:0] reg2,
   output logic                  halted,
   output logic                  busy
);

   localparam int DEPTH = 2**PC_BITS;

   generate
      if (INS_WIDTH != OP_BITS + 2*FIELD_BITS) begin : g_bad_width
         $error("instruction_fetch: INS_WIDTH must equal OP_BITS + 2*FIELD_BITS");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_state_next;

   logic [INS_WIDTH-1:0]   r_mem [DEPTH];
   logic [INS_WIDTH-1:0]   r_ins;
   logic [PC_BITS-1:0]     r_pc;
   logic [PC_BITS-1:0]     r_fetch_pc;
   logic                   r_ins_valid;

   logic [PC_BITS-1:0]     w_fetch_addr;
   logic [OP_BITS-1:0]     w_opcode;
   logic                   w_mem_we;
   logic                   w_fetch_en;
   logic                   w_start;
   logic                   w_halt;

   assign w_opcode = r_ins[INS_WIDTH-1 -: OP_BITS];

   // Relative branches are measured from the instruction currently presented.
   assign w_fetch_addr = branch_en ? (branch_rel ? r_pc + branch_target : branch_target)
                                   : r_fetch_pc;

   always_comb begin
      w_state_next = r_state;
      w_mem_we     = 1'b0;
      w_fetch_en   = 1'b0;
      w_start      = 1'b0;
      w_halt       = 1'b0;
      case (r_state)
         S_IDLE, S_HALT: begin
            w_mem_we = load_en & ~reset;
            if (start) begin
               w_state_next = S_RUN;
               w_start      = 1'b1;
            end
         end
         S_RUN: begin
            if (!stall) begin
               if (r_ins_valid && (w_opcode == HALT_OP)) begin
                  w_state_next = S_HALT;
                  w_halt       = 1'b1;
               end else begin
                  w_fetch_en = ~reset;
               end
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc        <= '0;
         r_fetch_pc  <= '0;
         r_ins_valid <= 1'b0;
      end else if (w_start) begin
         r_fetch_pc  <= START_PC;
         r_ins_valid <= 1'b0;
      end else if (w_halt) begin
         r_ins_valid <= 1'b0;
      end else if (w_fetch_en) begin
         r_pc        <= w_fetch_addr;
         r_fetch_pc  <= w_fetch_addr + PC_BITS'(1);
         r_ins_valid <= 1'b1;
      end
   end

   // Store has no reset; its output register does.
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[load_addr] <= load_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ins <= '0;
      end else if (w_fetch_en) begin
         r_ins <= r_mem[w_fetch_addr];
      end
   end

   assign pc        = r_pc;
   assign ins_valid = r_ins_valid;
   assign opcode    = w_opcode;
   assign reg1      = r_ins[2*FIELD_BITS-1 -: FIELD_BITS];
   assign reg2      = r_ins[FIELD_BITS-1:0];
   assign halted    = (r_state == S_HALT);
   assign busy      = (r_state == S_RUN);

endmodule
